// File: rtl/mem_rw_pkg.sv
// ----------------------------------------------------------------------------
// mem_rw_pkg : state encoding and error codes shared with the memory controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_rw_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WDAT = 3'd2,
    RDAT = 3'd3,
    ERR  = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [2:0] c_ERR_WR_TMO  = 3'd1;
  localparam logic [2:0] c_ERR_RD_TMO  = 3'd2;
  localparam logic [2:0] c_ERR_ACK_TMO = 3'd4;

  // Bus address of a byte: base plus index, wrapping inside the 64-byte space.
  function automatic logic [5:0] addr_at(input logic [5:0] base, input logic [3:0] idx);
    return base + {2'b00, idx};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_rw_wdog.sv
// ----------------------------------------------------------------------------
// mem_rw_wdog : counts cycles spent waiting for the controller acknowledge
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_rw_wdog #(
  parameter int ACK_TMO = 31
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int c_CNT_W = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(ACK_TMO - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires during the last permitted waiting cycle so the FSM leaves right after it.
  assign o_expired = i_enable && (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/mem_rw_initiator.sv
// ----------------------------------------------------------------------------
// mem_rw_initiator : turns byte-count read/write commands into bus transfers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_rw_initiator
  import mem_rw_pkg::*;
#(
  parameter int ACK_TMO = 31
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_wr,
  input  logic [5:0] i_cmd_addr,
  input  logic [3:0] i_cmd_num_b,
  input  logic [7:0] i_wdata,
  input  logic       i_wdata_valid,
  output logic       o_wdata_ready,
  output logic [7:0] o_rdata,
  output logic       o_rdata_valid,
  output logic       o_cmd_done,
  output logic       o_cmd_err,
  output logic [2:0] o_err_code,
  output logic       o_wr_req,
  output logic       o_rd_req,
  output logic [5:0] o_addr,
  output logic [3:0] o_num_b,
  input  logic       i_ack,
  output logic [7:0] o_wr_data,
  output logic       o_wr_valid,
  input  logic       i_wr_done,
  input  logic [7:0] i_rd_data,
  input  logic       i_rd_valid,
  output logic       o_rd_done,
  input  logic       i_err,
  input  logic [2:0] i_err_code,
  output logic       o_err_ack
);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_wr;
  logic [5:0] r_base;
  logic [3:0] r_num_b;
  logic [3:0] r_idx;
  logic [2:0] r_err_code;
  logic       r_err_report;
  logic       r_rd_done_q;
  logic [7:0] r_rdata;

  logic       w_accept;
  logic       w_wr_take;
  logic       w_rd_take;
  logic       w_active;
  logic       w_tmo;
  logic [3:0] w_idx_inc;

  assign w_accept  = (r_state == IDLE) && i_cmd_valid;
  assign w_wr_take = (r_state == WDAT) && i_wdata_valid && i_wr_done;
  assign w_rd_take = (r_state == RDAT) && i_rd_valid && !r_rd_done_q;
  assign w_active  = (r_state == REQ) || (r_state == WDAT) || (r_state == RDAT);
  assign w_idx_inc = r_idx + 4'd1;

  mem_rw_wdog #(
    .ACK_TMO (ACK_TMO)
  ) u_wdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_enable  (r_state == REQ),
    .i_clear   (r_state != REQ),
    .o_expired (w_tmo)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Controller error outranks acknowledge and completion in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (i_cmd_num_b == 4'd0) ? FIN : REQ;
        end
      end
      REQ: begin
        if (i_err) begin
          w_state_nxt = ERR;
        end else if (i_ack) begin
          w_state_nxt = r_wr ? WDAT : RDAT;
        end else if (w_tmo) begin
          w_state_nxt = ERR;
        end
      end
      WDAT: begin
        if (i_err) begin
          w_state_nxt = ERR;
        end else if (w_wr_take && (w_idx_inc == r_num_b)) begin
          w_state_nxt = FIN;
        end
      end
      RDAT: begin
        if (i_err) begin
          w_state_nxt = ERR;
        end else if (w_rd_take && (w_idx_inc == r_num_b)) begin
          w_state_nxt = FIN;
        end
      end
      ERR: begin
        w_state_nxt = r_err_report ? IDLE : ERR;
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr         <= 1'b0;
      r_base       <= '0;
      r_num_b      <= '0;
      r_idx        <= '0;
      r_err_code   <= '0;
      r_err_report <= 1'b0;
      r_rd_done_q  <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (w_accept) begin
        r_wr    <= i_cmd_wr;
        r_base  <= i_cmd_addr;
        r_num_b <= i_cmd_num_b;
        r_idx   <= '0;
      end else if (w_wr_take || w_rd_take) begin
        r_idx <= w_idx_inc;
      end

      r_rd_done_q <= w_rd_take;
      if (w_rd_take) begin
        r_rdata <= i_rd_data;
      end

      // A controller error is acknowledged first; a timeout is reported directly.
      if (w_active && i_err) begin
        r_err_code   <= i_err_code;
        r_err_report <= 1'b0;
      end else if ((r_state == REQ) && w_tmo && !i_ack) begin
        r_err_code   <= c_ERR_ACK_TMO;
        r_err_report <= 1'b1;
      end else if (r_state == ERR) begin
        r_err_report <= 1'b1;
      end
    end
  end

  assign o_cmd_ready   = (r_state == IDLE);
  assign o_wr_req      = (r_state == REQ) && r_wr;
  assign o_rd_req      = (r_state == REQ) && !r_wr;
  assign o_addr        = addr_at(r_base, r_idx);
  assign o_num_b       = r_num_b;
  assign o_wr_valid    = (r_state == WDAT) && i_wdata_valid;
  assign o_wr_data     = (r_state == WDAT) ? i_wdata : 8'd0;
  assign o_wdata_ready = w_wr_take;
  assign o_rd_done     = w_rd_take;
  assign o_rdata_valid = w_rd_take;
  assign o_rdata       = w_rd_take ? i_rd_data : r_rdata;
  assign o_cmd_done    = (r_state == FIN);
  assign o_err_ack     = (r_state == ERR) && !r_err_report;
  assign o_cmd_err     = (r_state == ERR) && r_err_report;
  assign o_err_code    = o_cmd_err ? r_err_code : 3'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_rw_initiator.sv
// ----------------------------------------------------------------------------
// tb_mem_rw_initiator : directed and random commands against a transaction model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_rw_initiator;

  localparam int ACK_TMO = 31;
  localparam int P_REQ  = 0;
  localparam int P_DATA = 1;
  localparam int P_DONE = 2;
  localparam int P_EACK = 3;
  localparam int P_EREP = 4;
  localparam int P_END  = 5;
  localparam logic [38:0] c_RST_OUT = {1'b1, 38'd0};

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_cmd_valid, i_cmd_wr;
  logic [5:0] i_cmd_addr;
  logic [3:0] i_cmd_num_b;
  logic [7:0] i_wdata;
  logic       i_wdata_valid;
  logic       o_cmd_ready, o_wdata_ready, o_rdata_valid, o_cmd_done, o_cmd_err;
  logic [7:0] o_rdata;
  logic [2:0] o_err_code;
  logic       o_wr_req, o_rd_req;
  logic [5:0] o_addr;
  logic [3:0] o_num_b;
  logic       i_ack;
  logic [7:0] o_wr_data;
  logic       o_wr_valid, i_wr_done;
  logic [7:0] i_rd_data;
  logic       i_rd_valid, o_rd_done, i_err;
  logic [2:0] i_err_code;
  logic       o_err_ack;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] mem [64];
  logic [7:0] src [16];

  always #5 i_clk = ~i_clk;

  mem_rw_initiator #(.ACK_TMO(ACK_TMO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
    .i_cmd_addr(i_cmd_addr), .i_cmd_num_b(i_cmd_num_b),
    .i_wdata(i_wdata), .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready),
    .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_cmd_done(o_cmd_done), .o_cmd_err(o_cmd_err), .o_err_code(o_err_code),
    .o_wr_req(o_wr_req), .o_rd_req(o_rd_req), .o_addr(o_addr), .o_num_b(o_num_b),
    .i_ack(i_ack), .o_wr_data(o_wr_data), .o_wr_valid(o_wr_valid), .i_wr_done(i_wr_done),
    .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid), .o_rd_done(o_rd_done),
    .i_err(i_err), .i_err_code(i_err_code), .o_err_ack(o_err_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    i_ack = 1'b0; i_err = 1'b0; i_err_code = 3'd0;
    i_wdata = 8'd0; i_wdata_valid = 1'b0; i_wr_done = 1'b0;
    i_rd_data = 8'd0; i_rd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(tag, 64'({o_cmd_ready, o_wr_req, o_rd_req, o_addr, o_num_b, o_wr_data, o_wr_valid,
                  o_wdata_ready, o_rdata, o_rdata_valid, o_rd_done, o_cmd_done, o_cmd_err,
                  o_err_code, o_err_ack}), 64'(c_RST_OUT));
  endtask

  // One command from offer to completion; src[] holds the bytes to write.
  task automatic run_cmd(input bit wr, input logic [5:0] base, input logic [3:0] num,
                         input int ack_dly, input bit noack, input int err_at,
                         input logic [2:0] ecode, input int rst_at);
    int phase, ph0, k, reqc, datac;
    bit prev_rd, drv_ack, drv_err, take, did_rst;
    logic [2:0] exp_code;
    @(negedge i_clk);
    clear_inputs();
    i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = base; i_cmd_num_b = num;
    #1 chk("cmd_ready_idle", 64'(o_cmd_ready), 64'(1));
    exp_code = ecode;
    phase = (num == 4'd0) ? P_DONE : P_REQ;
    k = 0; reqc = 0; datac = 0; prev_rd = 1'b0; did_rst = 1'b0;
    for (int cyc = 0; cyc < 400 && phase != P_END; cyc++) begin
      @(negedge i_clk);
      clear_inputs();
      i_cmd_valid = 1'b0;
      i_cmd_wr = 1'($urandom); i_cmd_addr = 6'($urandom); i_cmd_num_b = 4'($urandom);
      drv_ack = 1'b0; drv_err = 1'b0; take = 1'b0;
      ph0 = phase;
      if (phase == P_REQ && !noack && reqc == ack_dly) begin
        i_ack = 1'b1; drv_ack = 1'b1;
      end else if (phase == P_DATA) begin
        if (rst_at >= 0 && datac == rst_at) begin
          i_reset = 1'b0; did_rst = 1'b1;
        end else if (err_at >= 0 && k == err_at) begin
          i_err = 1'b1; i_err_code = ecode; drv_err = 1'b1;
        end else if (wr) begin
          i_wdata_valid = 1'($urandom); i_wr_done = 1'($urandom); i_wdata = src[k];
        end else begin
          i_rd_valid = 1'($urandom); i_rd_data = mem[(int'(base) + k) % 64];
        end
      end
      #1;
      if (did_rst) begin
        check_reset_outputs("reset_mid_cmd");
        @(negedge i_clk);
        i_reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge i_clk);
          #1 chk("no_completion_after_reset",
                 64'({o_cmd_done, o_cmd_err, o_cmd_ready}), 64'(3'b001));
        end
        phase = P_END;
        break;
      end
      chk("cmd_ready_busy", 64'(o_cmd_ready), 64'(0));
      chk("cmd_done_pulse", 64'(o_cmd_done), 64'(ph0 == P_DONE));
      chk("cmd_err_pulse", 64'(o_cmd_err), 64'(ph0 == P_EREP));
      case (ph0)
        P_REQ: begin
          chk("req_lines", 64'({o_wr_req, o_rd_req}), 64'({wr, !wr}));
          chk("req_num_b", 64'(o_num_b), 64'(num));
          chk("req_addr", 64'(o_addr), 64'(base));
          if (drv_ack) begin
            phase = P_DATA;
          end else begin
            reqc++;
            if (reqc == ACK_TMO) begin
              phase = P_EREP; exp_code = 3'd4;
            end
          end
        end
        P_DATA: begin
          chk("req_dropped", 64'({o_wr_req, o_rd_req}), 64'(0));
          if (wr) begin
            take = i_wdata_valid && i_wr_done;
            chk("wr_valid", 64'(o_wr_valid), 64'(i_wdata_valid));
            chk("wdata_ready", 64'(o_wdata_ready), 64'(take));
            if (take) begin
              chk("wr_data", 64'(o_wr_data), 64'(src[k]));
              chk("wr_addr", 64'(o_addr), 64'((int'(base) + k) % 64));
            end
          end else begin
            take = i_rd_valid && !prev_rd;
            chk("rd_done", 64'(o_rd_done), 64'(take));
            chk("rdata_valid", 64'(o_rdata_valid), 64'(take));
            if (take) begin
              chk("rdata", 64'(o_rdata), 64'(mem[(int'(base) + k) % 64]));
              chk("rd_addr", 64'(o_addr), 64'((int'(base) + k) % 64));
            end
            prev_rd = take;
          end
          if (drv_err) begin
            phase = P_EACK;
          end else if (take) begin
            k++;
            if (k == int'(num)) phase = P_DONE;
          end
          datac++;
        end
        P_DONE: begin
          chk("done_no_req", 64'({o_wr_req, o_rd_req, o_err_ack}), 64'(0));
          phase = P_END;
        end
        P_EACK: begin
          chk("err_ack", 64'(o_err_ack), 64'(1));
          phase = P_EREP;
        end
        P_EREP: begin
          chk("err_code", 64'(o_err_code), 64'(exp_code));
          chk("err_ack_quiet", 64'(o_err_ack), 64'(0));
          phase = P_END;
        end
        default: phase = P_END;
      endcase
    end
    if (phase != P_END) begin
      chk("cmd_timeout_phase", 64'(phase), 64'(P_END));
    end
    @(negedge i_clk);
    clear_inputs();
    #1 chk("back_to_idle", 64'(o_cmd_ready), 64'(1));
  endtask

  initial begin
    int num, err_at, rst_dummy;
    bit noack;
    i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = 6'd0; i_cmd_num_b = 4'd0;
    clear_inputs();
    for (int a = 0; a < 64; a++) mem[a] = 8'($urandom);
    repeat (2) @(negedge i_clk);
    #1 check_reset_outputs("reset_state");
    @(negedge i_clk);
    i_reset = 1'b1;

    src[0] = 8'hA1; src[1] = 8'hB2; src[2] = 8'hC3;
    run_cmd(1'b1, 6'd5, 4'd3, 2, 1'b0, -1, 3'd0, -1);
    run_cmd(1'b0, 6'd62, 4'd4, 1, 1'b0, -1, 3'd0, -1);
    run_cmd(1'b1, 6'd17, 4'd0, 0, 1'b0, -1, 3'd0, -1);
    run_cmd(1'b0, 6'd9, 4'd2, 0, 1'b1, -1, 3'd0, -1);
    run_cmd(1'b1, 6'd30, 4'd3, 0, 1'b0, 1, 3'd1, -1);
    run_cmd(1'b0, 6'd40, 4'd4, 1, 1'b0, -1, 3'd0, 2);

    rst_dummy = -1;
    for (int n = 0; n < 40; n++) begin
      num = $urandom_range(0, 15);
      for (int b = 0; b < 16; b++) src[b] = 8'($urandom);
      noack = ($urandom_range(0, 15) == 0);
      err_at = (num > 0 && $urandom_range(0, 7) == 0) ? $urandom_range(0, num - 1) : -1;
      run_cmd(1'($urandom), 6'($urandom), 4'(num), $urandom_range(0, 4), noack,
              err_at, 3'($urandom), rst_dummy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
